// File: rtl/tx_fcs_append.sv
// tx_fcs_append: passes an MPDU byte stream through unchanged and appends its 802.11 CRC-32 FCS
module tx_fcs_append #(
   parameter logic [31:0] CRC_INIT   = 32'hFFFFFFFF,
   parameter bit          FCS_INVERT = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  s_data,
   input  logic        s_valid,
   input  logic        s_last,
   output logic        s_ready,
   input  logic        fcs_bypass,
   output logic [7:0]  m_data,
   output logic        m_valid,
   output logic        m_last,
   input  logic        m_ready,
   output logic [31:0] fcs_out,
   output logic        fcs_done
);
   localparam logic [31:0] POLY = 32'h04C11DB7;

   typedef enum logic {PASS, FCS} state_t;

   state_t      state_q, state_d;
   logic [31:0] crc_q, crc_d;
   logic [31:0] fcs_out_q, fcs_out_d;
   logic [7:0]  m_data_q, m_data_d;
   logic        m_valid_q, m_valid_d;
   logic        m_last_q, m_last_d;
   logic        m_fcs_q, m_fcs_d;
   logic        sof_q, sof_d;
   logic        bypass_q, bypass_d;
   logic [1:0]  cnt_q, cnt_d;
   logic        slot_free, accept, eff_bypass;
   logic [31:0] fcs_word;

   // Eight serial MSB-first shift steps, LSB of the byte first, unrolled into one cycle
   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 8; i++)
         r = {r[30:0], 1'b0} ^ ((r[31] ^ d[i]) ? POLY : 32'h0);
      return r;
   endfunction

   assign slot_free  = ~m_valid_q | m_ready;
   assign s_ready    = ~rst & (state_q == PASS) & slot_free;
   assign accept     = s_valid & s_ready;
   assign eff_bypass = sof_q ? fcs_bypass : bypass_q;
   assign m_data     = m_data_q;
   assign m_valid    = m_valid_q;
   assign m_last     = m_last_q;
   assign fcs_out    = fcs_out_q;
   assign fcs_done   = m_valid_q & m_ready & m_last_q & m_fcs_q;

   // FCS word in transmit order: per-byte bit reversal of the CRC collapses to a full 32-bit reversal
   always_comb begin
      fcs_word = '0;
      for (int i = 0; i < 32; i++)
         fcs_word[i] = crc_q[31-i] ^ FCS_INVERT;
   end

   // Next-state: payload pass-through with CRC update, then four FCS bytes into the output slot
   always_comb begin
      state_d   = state_q;
      crc_d     = crc_q;
      fcs_out_d = fcs_out_q;
      m_data_d  = m_data_q;
      m_valid_d = m_valid_q;
      m_last_d  = m_last_q;
      m_fcs_d   = m_fcs_q;
      sof_d     = sof_q;
      bypass_d  = bypass_q;
      cnt_d     = cnt_q;
      if (state_q == PASS) begin
         if (accept) begin
            m_data_d  = s_data;
            m_valid_d = 1'b1;
            m_fcs_d   = 1'b0;
            m_last_d  = s_last & eff_bypass;
            crc_d     = crc_byte(crc_q, s_data);
            sof_d     = 1'b0;
            bypass_d  = eff_bypass;
            if (s_last && eff_bypass) begin
               crc_d = CRC_INIT;
               sof_d = 1'b1;
            end else if (s_last) begin
               state_d = FCS;
               cnt_d   = 2'd0;
            end
         end else if (slot_free) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
         end
      end else if (slot_free) begin
         m_data_d  = fcs_word[{cnt_q, 3'b000} +: 8];
         m_valid_d = 1'b1;
         m_fcs_d   = 1'b1;
         m_last_d  = (cnt_q == 2'd3);
         cnt_d     = cnt_q + 2'd1;
         if (cnt_q == 2'd3) begin
            fcs_out_d = fcs_word;
            crc_d     = CRC_INIT;
            sof_d     = 1'b1;
            state_d   = PASS;
         end
      end
   end

   // State registers; reset drops any partial frame immediately
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= PASS;
         crc_q     <= CRC_INIT;
         fcs_out_q <= '0;
         m_data_q  <= '0;
         m_valid_q <= 1'b0;
         m_last_q  <= 1'b0;
         m_fcs_q   <= 1'b0;
         sof_q     <= 1'b1;
         bypass_q  <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         crc_q     <= crc_d;
         fcs_out_q <= fcs_out_d;
         m_data_q  <= m_data_d;
         m_valid_q <= m_valid_d;
         m_last_q  <= m_last_d;
         m_fcs_q   <= m_fcs_d;
         sof_q     <= sof_d;
         bypass_q  <= bypass_d;
         cnt_q     <= cnt_d;
      end
   end
endmodule

// File: tb/tb_tx_fcs_append.sv
// tb_tx_fcs_append: randomized self-checking bench against a reflected CRC-32 reference model
module tb_tx_fcs_append;
   typedef logic [8:0] q9_t[$];
   typedef logic [7:0] qb_t[$];

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  s_data = '0;
   logic        s_valid = 1'b0, s_last = 1'b0, fcs_bypass = 1'b0, m_ready = 1'b1;
   logic        s_ready, m_valid, m_last, fcs_done;
   logic [7:0]  m_data;
   logic [31:0] fcs_out;
   logic        r_s_ready, r_m_valid, r_m_last, r_fcs_done;
   logic [7:0]  r_m_data;
   logic [31:0] r_fcs_out;

   int   checks = 0, failures = 0;
   int   done_cnt = 0, r_done_cnt = 0, low_cnt = 0, stall_viol = 0;
   q9_t  rx, rx_raw;
   bit   rnd_ready = 1'b0;
   logic prev_stall = 1'b0;
   logic [8:0] prev_out;

   tx_fcs_append dut (
      .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
      .fcs_bypass(fcs_bypass), .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
      .fcs_out(fcs_out), .fcs_done(fcs_done));

   tx_fcs_append #(.FCS_INVERT(1'b0)) dut_raw (
      .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(r_s_ready),
      .fcs_bypass(fcs_bypass), .m_data(r_m_data), .m_valid(r_m_valid), .m_last(r_m_last), .m_ready(m_ready),
      .fcs_out(r_fcs_out), .fcs_done(r_fcs_done));

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   always @(posedge clk) begin
      #1;
      if (rnd_ready) m_ready = 1'($urandom_range(0, 1));
   end

   // Output monitor, sampled mid-cycle
   always @(negedge clk) begin
      if (rst) prev_stall = 1'b0;
      else begin
         if (prev_stall && (m_valid !== 1'b1 || {m_last, m_data} !== prev_out)) stall_viol++;
         prev_stall = m_valid & ~m_ready;
         prev_out   = {m_last, m_data};
         if (m_valid & m_ready) rx.push_back({m_last, m_data});
         if (r_m_valid & m_ready) rx_raw.push_back({r_m_last, r_m_data});
         if (fcs_done) done_cnt++;
         if (r_fcs_done) r_done_cnt++;
         if (!s_ready) low_cnt++;
      end
   end

   // Reference: standard reflected CRC-32 (poly EDB88320), FCS appended low byte first
   task automatic build_exp(input qb_t p, input bit bp, input bit inv, inout q9_t e);
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      foreach (p[i]) begin
         e.push_back({bp && (i == p.size() - 1), p[i]});
         c = c ^ {24'h0, p[i]};
         repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      if (!bp) begin
         if (inv) c = ~c;
         for (int k = 0; k < 4; k++) e.push_back({k == 3, c[8*k +: 8]});
      end
   endtask

   function automatic int first_diff(input q9_t a, input q9_t b);
      int n;
      n = (a.size() > b.size()) ? a.size() : b.size();
      for (int i = 0; i < n; i++)
         if (i >= a.size() || i >= b.size() || a[i] !== b[i]) return i;
      return -1;
   endfunction

   function automatic logic [8:0] at(input q9_t a, input int i);
      return (i >= 0 && i < a.size()) ? a[i] : 9'bx;
   endfunction

   task automatic push(input logic [7:0] b, input bit last, input bit bp, input bit gaps);
      int  t;
      bit  hs;
      t  = 0;
      hs = 1'b0;
      if (gaps) while ($urandom_range(0, 2) == 0) begin s_valid = 1'b0; @(posedge clk); #1; end
      s_valid = 1'b1; s_data = b; s_last = last; fcs_bypass = bp;
      while (!hs && t < 500) begin
         @(negedge clk); hs = s_ready; t++;
         @(posedge clk); #1;
      end
      s_valid = 1'b0; s_last = 1'b0;
      if (!hs) begin
         checks++; failures++;
         $display("FAIL push_timeout: byte %h not accepted within 500 cycles", b);
      end
   endtask

   task automatic send(input qb_t p, input bit bp, input bit gaps, input bit toggle);
      foreach (p[i]) push(p[i], i == p.size() - 1, (i == 0 || !toggle) ? bp : 1'($urandom_range(0, 1)), gaps);
      fcs_bypass = 1'b0;
   endtask

   task automatic wait_rx(input int n, input string nm);
      int t;
      t = 0;
      while (rx.size() < n && t < 5000) begin @(posedge clk); t++; end
      if (rx.size() < n) begin
         checks++; failures++;
         $display("FAIL %s_timeout: got %0d bytes, required %0d", nm, rx.size(), n);
      end
      repeat (8) @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      rx.delete(); rx_raw.delete();
      done_cnt = 0; r_done_cnt = 0; low_cnt = 0; stall_viol = 0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL reset_s_ready: got %b required 0", s_ready); end
      checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid: got %b required 0", m_valid); end
      checks++; if (m_data !== 8'h00) begin failures++; $display("FAIL reset_m_data: got %h required 00", m_data); end
      checks++; if (m_last !== 1'b0) begin failures++; $display("FAIL reset_m_last: got %b required 0", m_last); end
      checks++; if (fcs_out !== 32'h0) begin failures++; $display("FAIL reset_fcs_out: got %h required 0", fcs_out); end
      checks++; if (fcs_done !== 1'b0) begin failures++; $display("FAIL reset_fcs_done: got %b required 0", fcs_done); end
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_check_value(input qb_t p9);
      q9_t e, er;
      int  d;
      e  = '{9'h031, 9'h032, 9'h033, 9'h034, 9'h035, 9'h036, 9'h037, 9'h038, 9'h039,
             9'h026, 9'h039, 9'h0F4, 9'h1CB};
      er = '{9'h031, 9'h032, 9'h033, 9'h034, 9'h035, 9'h036, 9'h037, 9'h038, 9'h039,
             9'h0D9, 9'h0C6, 9'h00B, 9'h134};
      clear_mon();
      send(p9, 1'b0, 1'b0, 1'b0);
      wait_rx(13, "check_value");
      d = first_diff(rx, e);
      checks++; if (d >= 0) begin failures++; $display("FAIL check_value_bytes: idx %0d got last|data %h required %h (got %0d bytes of %0d)", d, at(rx, d), at(e, d), rx.size(), e.size()); end
      checks++; if (fcs_out !== 32'hCBF43926) begin failures++; $display("FAIL check_value_fcs_out: got %h required cbf43926", fcs_out); end
      checks++; if (done_cnt != 1) begin failures++; $display("FAIL check_value_fcs_done: got %0d pulses required 1", done_cnt); end
      checks++; if (low_cnt != 4) begin failures++; $display("FAIL check_value_ready_low: got %0d cycles required 4", low_cnt); end
      d = first_diff(rx_raw, er);
      checks++; if (d >= 0) begin failures++; $display("FAIL raw_bytes: idx %0d got last|data %h required %h", d, at(rx_raw, d), at(er, d)); end
      checks++; if (r_fcs_out !== 32'h340BC6D9) begin failures++; $display("FAIL raw_fcs_out: got %h required 340bc6d9", r_fcs_out); end
   endtask

   task automatic test_single_zero();
      q9_t e;
      int  d;
      e = '{9'h000, 9'h08D, 9'h0EF, 9'h002, 9'h1D2};
      clear_mon();
      push(8'h00, 1'b1, 1'b0, 1'b0);
      wait_rx(5, "single_zero");
      d = first_diff(rx, e);
      checks++; if (d >= 0) begin failures++; $display("FAIL single_zero_bytes: idx %0d got last|data %h required %h", d, at(rx, d), at(e, d)); end
      checks++; if (fcs_out !== 32'hD202EF8D) begin failures++; $display("FAIL single_zero_fcs_out: got %h required d202ef8d", fcs_out); end
   endtask

   task automatic test_backpressure(input qb_t p9);
      q9_t e;
      int  d;
      e = {};
      build_exp(p9, 1'b0, 1'b1, e);
      clear_mon();
      rnd_ready = 1'b1;
      send(p9, 1'b0, 1'b1, 1'b0);
      wait_rx(e.size(), "backpressure");
      rnd_ready = 1'b0; m_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      d = first_diff(rx, e);
      checks++; if (d >= 0) begin failures++; $display("FAIL backpressure_bytes: idx %0d got last|data %h required %h (got %0d bytes of %0d)", d, at(rx, d), at(e, d), rx.size(), e.size()); end
      checks++; if (stall_viol != 0) begin failures++; $display("FAIL backpressure_stable: got %0d unstable stall cycles required 0", stall_viol); end
      checks++; if (done_cnt != 1) begin failures++; $display("FAIL backpressure_fcs_done: got %0d pulses required 1", done_cnt); end
   endtask

   task automatic test_back_to_back(input qb_t p9);
      q9_t e, er;
      qb_t z, bpf;
      int  d;
      z = '{8'h00}; bpf = '{8'hA1, 8'hB2, 8'hC3};
      e = {}; er = {};
      build_exp(p9, 1'b0, 1'b1, e);  build_exp(z, 1'b0, 1'b1, e);  build_exp(bpf, 1'b1, 1'b1, e);
      build_exp(p9, 1'b0, 1'b0, er); build_exp(z, 1'b0, 1'b0, er); build_exp(bpf, 1'b1, 1'b0, er);
      clear_mon();
      send(p9, 1'b0, 1'b0, 1'b1);
      send(z, 1'b0, 1'b0, 1'b0);
      send(bpf, 1'b1, 1'b0, 1'b1);
      wait_rx(e.size(), "back_to_back");
      d = first_diff(rx, e);
      checks++; if (d >= 0) begin failures++; $display("FAIL back_to_back_bytes: idx %0d got last|data %h required %h (got %0d bytes of %0d)", d, at(rx, d), at(e, d), rx.size(), e.size()); end
      d = first_diff(rx_raw, er);
      checks++; if (d >= 0) begin failures++; $display("FAIL back_to_back_raw: idx %0d got last|data %h required %h", d, at(rx_raw, d), at(er, d)); end
      checks++; if (done_cnt != 2) begin failures++; $display("FAIL back_to_back_fcs_done: got %0d pulses required 2", done_cnt); end
      checks++; if (fcs_out !== 32'hD202EF8D) begin failures++; $display("FAIL back_to_back_fcs_out: got %h required d202ef8d", fcs_out); end
   endtask

   task automatic test_reset_mid_frame(input qb_t p9);
      q9_t e;
      int  d, lasts;
      e = {};
      build_exp(p9, 1'b0, 1'b1, e);
      clear_mon();
      send(p9, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      checks++; if (m_valid !== 1'b0 || m_data !== 8'h00 || m_last !== 1'b0) begin failures++; $display("FAIL midreset_outputs: got valid %b data %h last %b required 0 00 0", m_valid, m_data, m_last); end
      checks++; if (fcs_out !== 32'h0 || fcs_done !== 1'b0 || s_ready !== 1'b0) begin failures++; $display("FAIL midreset_status: got fcs_out %h done %b s_ready %b required 0 0 0", fcs_out, fcs_done, s_ready); end
      lasts = 0;
      foreach (rx[i]) if (rx[i][8]) lasts++;
      checks++; if (lasts != 0 || rx.size() != 10) begin failures++; $display("FAIL midreset_partial: got %0d bytes with %0d m_last required 10 bytes with 0", rx.size(), lasts); end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk); #1;
      clear_mon();
      send(p9, 1'b0, 1'b0, 1'b0);
      wait_rx(e.size(), "midreset_next");
      d = first_diff(rx, e);
      checks++; if (d >= 0) begin failures++; $display("FAIL midreset_next_bytes: idx %0d got last|data %h required %h", d, at(rx, d), at(e, d)); end
      checks++; if (done_cnt != 1) begin failures++; $display("FAIL midreset_next_fcs_done: got %0d pulses required 1", done_cnt); end
   endtask

   task automatic test_random_frames();
      q9_t e;
      qb_t p;
      bit  bp[3];
      int  d, n_done;
      e = {};
      n_done = 0;
      clear_mon();
      rnd_ready = 1'b1;
      for (int f = 0; f < 3; f++) begin
         p = {};
         repeat ($urandom_range(1, 12)) p.push_back(8'($urandom_range(0, 255)));
         bp[f] = ($urandom_range(0, 3) == 0);
         if (!bp[f]) n_done++;
         build_exp(p, bp[f], 1'b1, e);
         send(p, bp[f], 1'b1, 1'b1);
      end
      wait_rx(e.size(), "random");
      rnd_ready = 1'b0; m_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      d = first_diff(rx, e);
      checks++; if (d >= 0) begin failures++; $display("FAIL random_bytes: idx %0d got last|data %h required %h (got %0d bytes of %0d)", d, at(rx, d), at(e, d), rx.size(), e.size()); end
      checks++; if (done_cnt != n_done) begin failures++; $display("FAIL random_fcs_done: got %0d pulses required %0d", done_cnt, n_done); end
      checks++; if (stall_viol != 0) begin failures++; $display("FAIL random_stable: got %0d unstable stall cycles required 0", stall_viol); end
   endtask

   initial begin
      qb_t p9;
      p9 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      test_reset();
      test_check_value(p9);
      test_single_zero();
      test_backpressure(p9);
      test_back_to_back(p9);
      test_reset_mid_frame(p9);
      for (int r = 0; r < 4; r++) test_random_frames();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/tx_fcs_append.md
Name: tx_fcs_append

Overview:
Transmit-side 802.11 FCS generator. It passes an MPDU byte stream through unchanged, computing CRC-32 on the fly, then appends the 4-byte FCS after the last payload byte. It sits between the TX MAC byte source and the scrambler/encoder front end. Its output, fed back through the RX chain, passes the receiver's CRC-32 check.

Parameters:
CRC_INIT, 32'hFFFFFFFF, CRC register value at reset and at the start of each frame.
FCS_INVERT, 1, 1 = FCS is the ones-complement of the CRC (802.11); 0 = raw CRC, for debug only.

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
s_data  input  8  payload byte; bit 0 is first on air
s_valid  input  1  s_data valid
s_last  input  1  marks final payload byte of the frame
s_ready  output  1  block accepts s_data this cycle
fcs_bypass  input  1  sampled with the first byte of a frame; 1 = pass the frame through without appending FCS
m_data  output  8  output byte (payload, then FCS)
m_valid  output  1  m_data valid
m_last  output  1  final byte of the output frame
m_ready  input  1  downstream accepts m_data
fcs_out  output  32  last computed FCS word (bit-ordered as transmitted, byte0 = [7:0])
fcs_done  output  1  one-cycle pulse when the final FCS byte is accepted downstream

Behaviour:
- Reset values: s_ready=0 while rst is high. m_data=0, m_valid=0, m_last=0, fcs_out=0, fcs_done=0. CRC=CRC_INIT, state=PASS, sof=1, byte counter=0.
- CRC update, per accepted byte: 8 serial steps, bit order d[0] first up to d[7]. Each step: fb=c[31]^bit; c={c[30:0],0}^(fb?32'h04C11DB7:0). The implementation is a parallel single-cycle equivalent.
- FCS byte k (k=0..3, sent in k order): bitrev8(c[31-8k:24-8k]), inverted when FCS_INVERT=1. This equals the standard reflected CRC-32, low byte first.
- Output slot is a single register stage. A slot is free when ~m_valid | m_ready. m_data, m_last and m_valid are held stable while m_valid & ~m_ready.
- State PASS:
  - s_ready = slot free.
  - On accept (s_valid & s_ready), next cycle: m_data=s_data, m_valid=1, CRC updated, sof=0.
  - On the sof byte, fcs_bypass is latched into bypass_q. Changes to fcs_bypass mid-frame are ignored.
  - Accept with s_last, bypass (effective value = latched or sof-sampled) = 1: m_last=1, CRC reloads CRC_INIT, sof=1, stay in PASS.
  - Accept with s_last, bypass = 0: m_last=0, go to FCS with cnt=0. CRC holds the final value.
  - No accept and slot free: m_valid drops to 0.
- State FCS:
  - s_ready=0.
  - Each cycle the slot is free: load FCS byte cnt, m_valid=1, m_last=(cnt==3), cnt++.
  - On loading cnt==3: fcs_out=full FCS word, CRC reloads CRC_INIT, sof=1, return to PASS. s_ready may assert in the same cycle the last FCS byte sits in the slot.
  - fcs_done pulses in the cycle the m_last FCS byte handshakes (m_valid & m_ready & m_last & ~bypassed frame).
- Latency and throughput:
  - Payload latency is 1 cycle from accept to m_valid.
  - Sustains 1 byte/cycle with m_ready held high.
  - Overhead is exactly 4 cycles of s_ready=0 per FCS-appended frame.
- Frame boundaries: a frame has at least one byte, since s_last always rides a byte. Back-to-back frames need no idle cycle beyond the FCS insertion. The CRC never carries over between frames.
- Reset mid-frame: all state returns to reset values immediately. The partial frame is dropped with no m_last. The next accepted byte starts a new frame with CRC=CRC_INIT.
- Downstream stall in FCS state: cnt does not advance and the CRC register is not modified.

Test Plan:
- Frame "123456789" (0x31..0x39), m_ready=1, bypass=0 -> m_data: 31..39 then 26 39 F4 CB. m_last only on CB. fcs_out=32'hCBF43926. One fcs_done pulse. s_ready low for exactly 4 cycles.
- Single byte 0x00 with s_last -> output 00 8D EF 02 D2, m_last on D2.
- "123456789" with pseudo-random m_ready (≈50%) and gapped s_valid -> identical byte sequence. m_data stable whenever m_valid & ~m_ready. No byte lost or duplicated.
- Two back-to-back frames, "123456789" then 0x00 -> second FCS is 8D EF 02 D2, proving CRC reinit. fcs_bypass=1 frame of 3 bytes A1 B2 C3 -> exactly 3 output bytes, m_last on C3, no fcs_done. Toggling fcs_bypass mid-frame has no effect.
- Assert rst during the second FCS byte -> outputs go to reset values within the reset cycle. A following "123456789" frame produces 26 39 F4 CB.
- FCS_INVERT=0 build, "123456789" -> FCS bytes D9 C6 0B 34, the non-inverted CRC (~32'hCBF43926 = 32'h340BC6D9, sent low byte first).
